// File: rtl/sa_leaf_pkg.sv
// Shared defaults, statistics record and pointer wrap helper for the leaf-stage FIFO.
package sa_leaf_pkg;

    localparam int SA_LEAF_DEPTH_DEF = 4;
    localparam int SA_LEAF_WIDTH_DEF = 8;
    localparam int SA_LEAF_STAT_W    = 16;

    typedef struct packed {
        logic [SA_LEAF_STAT_W-1:0] push_total;
        logic [SA_LEAF_STAT_W-1:0] pop_total;
        logic [SA_LEAF_STAT_W-1:0] hwm;
    } sa_leaf_stats_t;

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr + 32'd1) % depth;
    endfunction

endpackage

// File: rtl/sa_leaf_stats.sv
// Transfer counters and occupancy high-water mark for the leaf-stage FIFO.
// Only instantiated when SA_LEAF_FIFO_STATS_EN is defined.
module sa_leaf_stats
    import sa_leaf_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [CNT_W-1:0]          count_i,
    output logic [SA_LEAF_STAT_W-1:0] push_total_o,
    output logic [SA_LEAF_STAT_W-1:0] pop_total_o,
    output logic [CNT_W-1:0]          hwm_o
);

    sa_leaf_stats_t stats_q, stats_d;

    function automatic logic [SA_LEAF_STAT_W-1:0] sat_inc(input logic [SA_LEAF_STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // count_i is next-state occupancy, so the mark tracks count without lag
    always_comb begin
        stats_d = stats_q;
        if (push_i) stats_d.push_total = sat_inc(stats_q.push_total);
        if (pop_i)  stats_d.pop_total  = sat_inc(stats_q.pop_total);
        if (SA_LEAF_STAT_W'(count_i) > stats_q.hwm) stats_d.hwm = SA_LEAF_STAT_W'(count_i);
    end

    always_ff @(posedge clk) begin
        if (rst) stats_q <= '0;
        else     stats_q <= stats_d;
    end

    assign push_total_o = stats_q.push_total;
    assign pop_total_o  = stats_q.pop_total;
    assign hwm_o        = stats_q.hwm[CNT_W-1:0];

endmodule

// File: rtl/sa_leaf_stage_fifo.sv
// First-word-fall-through valid/ready FIFO for the leaf tier of the generated hierarchy.
// Optional transfer statistics are enabled with SA_LEAF_FIFO_STATS_EN.
module sa_leaf_stage_fifo
    import sa_leaf_pkg::*;
#(
    parameter int WIDTH = SA_LEAF_WIDTH_DEF,
    parameter int DEPTH = SA_LEAF_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef SA_LEAF_FIFO_STATS_EN
    output logic [15:0]      push_total,
    output logic [15:0]      pop_total,
    output logic [CNT_W-1:0] hwm,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Full is judged from count alone; a pop never frees a slot in the same cycle
    assign in_ready  = !rst && !flush && (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
            if (pop)  rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; stale words are masked by out_valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef SA_LEAF_FIFO_STATS_EN
    sa_leaf_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .count_i      (rst ? '0 : count_d),
        .push_total_o (push_total),
        .pop_total_o  (pop_total),
        .hwm_o        (hwm)
    );
`endif

endmodule

// File: tb/tb_sa_leaf_stage_fifo.sv
// Scoreboard bench for sa_leaf_stage_fifo: directed test-plan sequences followed by random traffic.
module tb_sa_leaf_stage_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
`ifdef SA_LEAF_FIFO_STATS_EN
    logic [15:0]      push_total, pop_total;
    logic [CNT_W-1:0] hwm;
`endif

    sa_leaf_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SA_LEAF_FIFO_STATS_EN
        .push_total(push_total),
        .pop_total (pop_total),
        .hwm       (hwm),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Reference model: the FIFO contents as a plain queue
    logic [WIDTH-1:0] mq[$];
    int sz;
    bit acc_push, acc_pop;
    int m_push_tot, m_pop_tot, m_hwm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model away from the edge, then predict the next edge
    always @(negedge clk) begin
        if (mon_en) begin
            sz = mq.size();
            chk("in_ready", 32'(in_ready), 32'(!rst && !flush && (sz < DEPTH)));
            chk("count", 32'(count), 32'(sz));
            chk("out_valid", 32'(out_valid), 32'(sz != 0));
            if (sz != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
            else         chk("out_data_empty", 32'(out_data), 32'd0);
`ifdef SA_LEAF_FIFO_STATS_EN
            chk("push_total", 32'(push_total), 32'(m_push_tot));
            chk("pop_total", 32'(pop_total), 32'(m_pop_tot));
            chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
            if (rst) begin
                mq.delete();
                m_push_tot = 0;
                m_pop_tot  = 0;
                m_hwm      = 0;
            end else if (flush) begin
                mq.delete();
            end else begin
                acc_push = in_valid && (sz < DEPTH);
                acc_pop  = out_ready && (sz != 0);
                if (acc_pop) begin
                    void'(mq.pop_front());
                    if (m_pop_tot < 16'hFFFF) m_pop_tot++;
                end
                if (acc_push) begin
                    mq.push_back(in_data);
                    if (m_push_tot < 16'hFFFF) m_push_tot++;
                end
                if (mq.size() > m_hwm) m_hwm = mq.size();
            end
        end
    end

    task automatic step(input bit r, input bit f, input bit v, input logic [WIDTH-1:0] d, input bit o);
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_push_tot = 0;
        m_pop_tot  = 0;
        m_hwm      = 0;
        // Reset held three cycles with in_valid high
        step(1, 0, 1, 8'hAA, 0);
        mon_en = 1'b1;
        step(1, 0, 1, 8'hAA, 0);
        step(1, 0, 1, 8'hAA, 0);
        // Fill, then an extra push that must be refused
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 0);
        step(0, 0, 1, 8'h33, 0);
        step(0, 0, 1, 8'h44, 0);
        step(0, 0, 1, 8'h55, 0);
        step(0, 0, 1, 8'h66, 1);
        // Drain the remaining entries
        repeat (5) step(0, 0, 0, 8'h00, 1);
        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) step(0, 0, 1, 8'(i), 1);
        step(0, 0, 0, 8'h00, 1);
        // Flush collision at count 2
        step(0, 0, 1, 8'hA1, 0);
        step(0, 0, 1, 8'hA2, 0);
        step(0, 1, 1, 8'hA3, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        // Stats sequence: 6 pushes, 4 pops, peak 3, then flush
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'hB0 + i), 0);
        repeat (2) step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 8'(8'hC0 + i), 0);
        repeat (2) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'hD0, 0);
        step(0, 1, 0, 8'h00, 0);
        repeat (2) step(0, 0, 0, 8'h00, 0);
        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 80) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
                 8'($urandom), ($urandom % 3) != 0);
        end
        step(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
